// File: rtl/lut_seq_pkg.sv
// Shared types and defaults for the time-multiplexed LogicNets layer sequencer.
// Holds the FSM state type, the default geometry and the table RAM depth helper.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefNumNeurons = 8;
  localparam int unsigned DefAddrW      = 6;
  localparam int unsigned DefOutW       = 2;

  // Every neuron owns a contiguous 2^addr_w slice of the shared table.
  function automatic int unsigned ram_depth(input int unsigned num_neurons,
                                            input int unsigned addr_w);
    return num_neurons << addr_w;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Shared truth-table storage: one synchronous write port, one synchronous read port.
// Contents are intentionally not reset so tables survive a sequencer reset.
module lut_table_ram #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 2,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_layer_sequencer.sv
// Evaluates one LogicNets layer by stepping every neuron through a single shared table RAM,
// one neuron per cycle, and returns the packed result vector on a valid/ready stream.
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DefNumNeurons,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned OUT_W       = DefOutW,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_NEURONS*ADDR_W-1:0] in_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*OUT_W-1:0]  out_data,
  input  logic                          cfg_we,
  output logic                          cfg_ready,
  input  logic [IDX_W+ADDR_W-1:0]       cfg_addr,
  input  logic [OUT_W-1:0]              cfg_data,
  output logic                          busy
);

  localparam int unsigned RamDepth = ram_depth(NUM_NEURONS, ADDR_W);
  localparam int unsigned RamAddrW = IDX_W + ADDR_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);

  state_e                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              idx_d_q;
  logic                          rd_pending_q;
  logic [NUM_NEURONS*ADDR_W-1:0] addr_q;
  logic                          out_valid_q;
  logic [NUM_NEURONS*OUT_W-1:0]  out_data_q;

  logic [ADDR_W-1:0]             sel_addr;
  logic [RamAddrW-1:0]           rd_addr;
  logic [OUT_W-1:0]              rd_data;
  logic                          ram_we;
  logic                          ram_re;

  assign cfg_ready = (state_q == StIdle);
  assign in_ready  = (state_q == StIdle) && !cfg_we;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Config writes are only ever accepted in IDLE, so they never collide with a read.
  assign ram_we = cfg_we && cfg_ready;
  assign ram_re = (state_q == StRun);

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_addr = addr_q[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign rd_addr = {idx_q, sel_addr};

  lut_table_ram #(
    .Depth (RamDepth),
    .Width (OUT_W),
    .AddrW (RamAddrW)
  ) u_table_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      idx_d_q      <= '0;
      rd_pending_q <= 1'b0;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      rd_pending_q <= (state_q == StRun);

      // Read data lags the issued index by one cycle; idx_d_q names its slot.
      if (rd_pending_q) begin
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
          if (idx_d_q == IDX_W'(i)) begin
            out_data_q[i*OUT_W +: OUT_W] <= rd_data;
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            addr_q     <= in_addr;
            idx_q      <= '0;
            out_data_q <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          idx_d_q <= idx_q;
          if (idx_q == LastIdx) begin
            state_q <= StDrain;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDrain: begin
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: a reference table model feeds a scoreboard
// of expected result vectors that is drained as the DUT completes each handshake.
module tb_lut_layer_sequencer;

  localparam int N  = 8;
  localparam int AW = 6;
  localparam int OW = 2;
  localparam int IW = 3;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*AW-1:0] in_addr;
  logic            out_valid;
  logic            out_ready;
  logic [N*OW-1:0] out_data;
  logic            cfg_we;
  logic            cfg_ready;
  logic [IW+AW-1:0] cfg_addr;
  logic [OW-1:0]   cfg_data;
  logic            busy;

  lut_layer_sequencer #(
    .NUM_NEURONS (N),
    .ADDR_W      (AW),
    .OUT_W       (OW),
    .IDX_W       (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [OW-1:0]   model [N][1<<AW];
  logic [N*OW-1:0] exp_q [$];
  int              cyc = 0;
  int              acc_cyc = 0;
  int              hs_cyc = 0;
  logic            ov_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*OW-1:0] exp_out(input logic [N*AW-1:0] vec);
    logic [N*OW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*OW +: OW] = model[i][vec[i*AW +: AW]];
    return r;
  endfunction

  function automatic logic [N*AW-1:0] mk_vec(input int n0, input int a0, input int n1, input int a1);
    logic [N*AW-1:0] v;
    v = '0;
    v[n0*AW +: AW] = AW'(a0);
    v[n1*AW +: AW] = AW'(a1);
    return v;
  endfunction

  // Scoreboard: push on input acceptance, pop and compare on output handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
      ov_prev <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_out(in_addr));
        acc_cyc <= cyc;
      end
      if (out_valid && !ov_prev) check_eq("latency", 64'(cyc - acc_cyc - 1), 64'(N + 1));
      ov_prev <= out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
        else check_eq("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
        hs_cyc <= cyc;
      end
    end
  end

  // Called on a negedge; returns on the following negedge.
  task automatic cfg_write(input int n, input int e, input logic [OW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = {IW'(n), AW'(e)};
    cfg_data = d;
    #1;
    if (cfg_ready) model[n][e] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [N*AW-1:0] vec);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_addr  = vec;
    for (int k = 0; k < 60 && !done; k++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check_eq("out_timeout", 64'(seen), 64'd1);
  endtask

  logic [N*AW-1:0] vec1, vec3, vec4, veca, vecb;
  logic [N*OW-1:0] hold;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < N; n++)
      for (int e = 0; e < (1 << AW); e++) cfg_write(n, e, 2'b00);

    // Config then evaluate
    cfg_write(0, 16, 2'b10);
    cfg_write(1, 8, 2'b11);
    vec1 = mk_vec(0, 16, 1, 8);
    send(vec1);
    wait_out();
    check_eq("s1_slot0", 64'(out_data[1:0]), 64'd2);
    check_eq("s1_slot1", 64'(out_data[3:2]), 64'd3);
    check_eq("s1_rest", 64'(out_data[15:4]), 64'd0);

    // Backpressure
    hold = exp_out(vec1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_data", 64'(out_data), 64'(hold));
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Collision: config wins, vector taken next cycle
    vec3 = mk_vec(3, 5, 0, 16);
    cfg_we = 1'b1; cfg_addr = {IW'(3), AW'(5)}; cfg_data = 2'b01;
    in_valid = 1'b1; in_addr = vec3;
    #1;
    check_eq("col_in_ready", 64'(in_ready), 64'd0);
    check_eq("col_cfg_ready", 64'(cfg_ready), 64'd1);
    if (cfg_ready) model[3][5] = 2'b01;
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check_eq("col_accept_next", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("col_busy", 64'(busy), 64'd1);
    wait_out();
    check_eq("col_slot3", 64'(out_data[7:6]), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Config while busy is ignored
    vec4 = mk_vec(2, 1, 1, 8);
    send(vec4);
    cfg_we = 1'b1; cfg_addr = {IW'(2), AW'(1)}; cfg_data = 2'b01;
    #1;
    check_eq("busy_cfg_ready", 64'(cfg_ready), 64'd0);
    check_eq("busy_busy", 64'(busy), 64'd1);
    if (cfg_ready) model[2][1] = 2'b01;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_out();
    out_ready = 1'b1;
    @(negedge clk);
    send(vec4);
    wait_out();
    check_eq("busy_slot2", 64'(out_data[5:4]), 64'd0);
    @(negedge clk);

    // Reset mid-RUN, tables retained
    out_ready = 1'b0;
    send(vec1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send(vec1);
    wait_out();
    check_eq("post_rst_slot0", 64'(out_data[1:0]), 64'd2);
    check_eq("post_rst_slot1", 64'(out_data[3:2]), 64'd3);
    @(negedge clk);

    // Back-to-back with constant out_ready
    cfg_write(4, 7, 2'b10);
    cfg_write(5, 9, 2'b01);
    veca = mk_vec(4, 7, 0, 16);
    vecb = mk_vec(5, 9, 1, 8);
    send(veca);
    send(vecb);
    check_eq("b2b_gap", 64'(acc_cyc - hs_cyc), 64'd1);
    wait_out();
    check_eq("b2b_slot5", 64'(out_data[11:10]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
